// File: rtl/ysyx_22040088_pkg.sv
// Shared LSU definitions: one-hot size masks, FSM states, alignment helper.
// Imported by ysyx_22040088_lsu and ysyx_22040088_lsu_align.
package ysyx_22040088_pkg;

  localparam logic [3:0] MASK_D = 4'b0001;
  localparam logic [3:0] MASK_W = 4'b0010;
  localparam logic [3:0] MASK_H = 4'b0100;
  localparam logic [3:0] MASK_B = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic misaligned(
    input logic [3:0] m,
    input logic [2:0] lo
  );
    return ((m == MASK_D) && (lo != 3'd0))
        || ((m == MASK_W) && (lo[1:0] != 2'd0))
        || ((m == MASK_H) && lo[0]);
  endfunction

endpackage

// File: rtl/ysyx_22040088_lsu_align.sv
// LSU lane logic: byte strobes, store replication, load shift and extend.
// Offsets are forced down to the access size; mask must be one-hot or zero.
module ysyx_22040088_lsu_align
  import ysyx_22040088_pkg::*;
(
  input  logic [3:0]  i_mask,
  input  logic [2:0]  i_off,
  input  logic        i_wen,
  input  logic        i_unsigned,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_rdata,
  output logic [7:0]  o_wstrb,
  output logic [63:0] o_wdata,
  output logic [63:0] o_rdata
);

  logic [7:0]  w_ones;
  logic [2:0]  w_off;
  logic [63:0] w_shift;
  logic        w_sx;

  always_comb begin
    w_ones  = 8'h00;
    w_off   = 3'd0;
    o_wdata = 64'd0;
    unique case (1'b1)
      (i_mask == MASK_D): begin
        w_ones  = 8'hFF;
        o_wdata = i_wdata;
      end
      (i_mask == MASK_W): begin
        w_ones  = 8'h0F;
        w_off   = {i_off[2], 2'b00};
        o_wdata = {2{i_wdata[31:0]}};
      end
      (i_mask == MASK_H): begin
        w_ones  = 8'h03;
        w_off   = {i_off[2:1], 1'b0};
        o_wdata = {4{i_wdata[15:0]}};
      end
      (i_mask == MASK_B): begin
        w_ones  = 8'h01;
        w_off   = i_off;
        o_wdata = {8{i_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  assign o_wstrb = i_wen ? (w_ones << w_off) : 8'h00;
  assign w_shift = i_rdata >> {w_off, 3'b000};
  assign w_sx    = ~i_unsigned;

  always_comb begin
    o_rdata = 64'd0;
    unique case (1'b1)
      (i_mask == MASK_D):
        o_rdata = w_shift;
      (i_mask == MASK_W):
        o_rdata = {{32{w_sx & w_shift[31]}}, w_shift[31:0]};
      (i_mask == MASK_H):
        o_rdata = {{48{w_sx & w_shift[15]}}, w_shift[15:0]};
      (i_mask == MASK_B):
        o_rdata = {{56{w_sx & w_shift[7]}}, w_shift[7:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_22040088_lsu.sv
// Load/store unit: request FSM between core and 64-bit bus.
// YSYX_22040088_LSU_MISALIGN_CHK_EN rejects misaligned accesses.
module ysyx_22040088_lsu
  import ysyx_22040088_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [3:0]  in_mask,
  input  logic        in_unsigned,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_rdata,
  output logic        out_err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [63:0] bus_addr,
  output logic        bus_wen,
  output logic [7:0]  bus_wstrb,
  output logic [63:0] bus_wdata,
  input  logic        bus_resp_valid,
  input  logic [63:0] bus_resp_rdata
);

  state_t      r_state;
  state_t      w_next;
  logic        r_wen;
  logic [3:0]  r_mask;
  logic        r_unsigned;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [63:0] r_rdata;
  logic        r_err;
  logic        w_err;
  logic        w_accept;
  logic [63:0] w_ldata;

`ifdef YSYX_22040088_LSU_MISALIGN_CHK_EN
  assign w_err = !$onehot(in_mask)
              || misaligned(in_mask, in_addr[2:0]);
`else
  assign w_err = !$onehot(in_mask);
`endif

  assign w_accept = (r_state == S_IDLE) && in_valid;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid)
                w_next = w_err ? S_DONE : S_REQ;
      S_REQ:  if (bus_req_ready)  w_next = S_WAIT;
      S_WAIT: if (bus_resp_valid) w_next = S_DONE;
      S_DONE: if (out_ready)      w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Rejected masks are stored as zero so the lane logic stays idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen      <= 1'b0;
      r_mask     <= 4'd0;
      r_unsigned <= 1'b0;
      r_addr     <= 64'd0;
      r_wdata    <= 64'd0;
      r_rdata    <= 64'd0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wen      <= in_wen;
        r_mask     <= w_err ? 4'd0 : in_mask;
        r_unsigned <= in_unsigned;
        r_addr     <= in_addr;
        r_wdata    <= in_wdata;
        r_rdata    <= 64'd0;
        r_err      <= w_err;
      end
      if ((r_state == S_WAIT) && bus_resp_valid)
        r_rdata <= r_wen ? 64'd0 : w_ldata;
    end
  end

  ysyx_22040088_lsu_align u_align (
    .i_mask     (r_mask),
    .i_off      (r_addr[2:0]),
    .i_wen      (r_wen),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .i_rdata    (bus_resp_rdata),
    .o_wstrb    (bus_wstrb),
    .o_wdata    (bus_wdata),
    .o_rdata    (w_ldata)
  );

  assign in_ready      = (r_state == S_IDLE);
  assign out_valid     = (r_state == S_DONE);
  assign bus_req_valid = (r_state == S_REQ);
  assign bus_addr      = {r_addr[63:3], 3'b000};
  assign bus_wen       = r_wen;
  assign out_rdata     = r_rdata;
  assign out_err       = r_err;

endmodule

// File: tb/tb_ysyx_22040088_lsu.sv
// Scoreboard bench for ysyx_22040088_lsu with a byte-level reference model.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_ysyx_22040088_lsu;

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [7:0]  wstrb;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } bus_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_wen;
  logic [3:0]  in_mask;
  logic        in_unsigned;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_rdata;
  logic        out_err;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [63:0] bus_addr;
  logic        bus_wen;
  logic [7:0]  bus_wstrb;
  logic [63:0] bus_wdata;
  logic        bus_resp_valid;
  logic [63:0] bus_resp_rdata;

  int   errs = 0;
  int   checks = 0;
  exp_t exp_q[$];
  bus_t bus_q[$];
  bit   bus_en = 1'b1;
  int   resp_wait = 0;
  int   stall_n = 0;
  logic [63:0] resp_data;

  ysyx_22040088_lsu dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_wen         (in_wen),
    .in_mask        (in_mask),
    .in_unsigned    (in_unsigned),
    .in_addr        (in_addr),
    .in_wdata       (in_wdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_rdata      (out_rdata),
    .out_err        (out_err),
    .bus_req_valid  (bus_req_valid),
    .bus_req_ready  (bus_req_ready),
    .bus_addr       (bus_addr),
    .bus_wen        (bus_wen),
    .bus_wstrb      (bus_wstrb),
    .bus_wdata      (bus_wdata),
    .bus_resp_valid (bus_resp_valid),
    .bus_resp_rdata (bus_resp_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errs++;
    $display("FAIL %s", nm);
  endtask

  // Reference: size in bytes, byte-lane arithmetic, no state machine.
  function automatic void model(
    input  logic        wen,
    input  logic [3:0]  mask,
    input  logic        uns,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    output exp_t        e,
    output bit          use_bus,
    output bus_t        b
  );
    int n;
    int off;
    logic [63:0] v;
    case (mask)
      4'b0001: n = 8;
      4'b0010: n = 4;
      4'b0100: n = 2;
      4'b1000: n = 1;
      default: n = 0;
    endcase
    e.err = (n == 0);
`ifdef YSYX_22040088_LSU_MISALIGN_CHK_EN
    if (n != 0 && (int'(addr[2:0]) % n) != 0) e.err = 1'b1;
`endif
    use_bus = !e.err;
    off = (n == 0) ? 0 : (int'(addr[2:0]) / n) * n;
    b.addr  = addr & ~64'h7;
    b.wen   = wen;
    b.rdata = rdata;
    b.wstrb = 8'h00;
    b.wdata = 64'd0;
    for (int i = 0; i < 8; i++) begin
      b.wstrb[i] = wen && (i >= off) && (i < off + n);
      if (n > 0) b.wdata[i*8 +: 8] = wdata[(i % n)*8 +: 8];
    end
    v = 64'd0;
    for (int i = 0; i < n; i++)
      v[i*8 +: 8] = rdata[(off + i)*8 +: 8];
    if (!uns && n > 0 && n < 8 && v[n*8-1])
      for (int i = n*8; i < 64; i++) v[i] = 1'b1;
    e.rdata = (e.err || wen) ? 64'd0 : v;
  endfunction

  task automatic issue(input logic        wen,
                       input logic [3:0]  mask,
                       input logic        uns,
                       input logic [63:0] addr,
                       input logic [63:0] wdata,
                       input exp_t        e,
                       input bit          use_bus,
                       input bus_t        b);
    int k = 0;
    @(negedge clk);
    while (!in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      fail_now("issue_timeout");
      return;
    end
    in_valid    = 1'b1;
    in_wen      = wen;
    in_mask     = mask;
    in_unsigned = uns;
    in_addr     = addr;
    in_wdata    = wdata;
    exp_q.push_back(e);
    if (use_bus) bus_q.push_back(b);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (k < 600 && (exp_q.size() != 0 || bus_q.size() != 0
           || resp_wait != 0 || !in_ready)) begin
      @(negedge clk);
      k++;
    end
    if (k >= 600) fail_now("drain_timeout");
  endtask

  task automatic rand_txn();
    logic        wen;
    logic [3:0]  mask;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    exp_t        e;
    bus_t        b;
    bit          ub;
    int          sel;
    wen   = 1'($urandom_range(0, 1));
    uns   = 1'($urandom_range(0, 1));
    sel   = $urandom_range(0, 9);
    case (sel)
      0, 1:    mask = 4'b0001;
      2, 3:    mask = 4'b0010;
      4, 5:    mask = 4'b0100;
      6, 7:    mask = 4'b1000;
      default: mask = 4'($urandom_range(0, 15));
    endcase
    addr  = {32'd0, $urandom};
    wdata = {$urandom, $urandom};
    rdata = {$urandom, $urandom};
    model(wen, mask, uns, addr, wdata, rdata, e, ub, b);
    issue(wen, mask, uns, addr, wdata, e, ub, b);
  endtask

  // Bus slave: random ready, delayed responses, stray resp pulses.
  initial begin
    bus_t bb;
    bus_req_ready  = 1'b0;
    bus_resp_valid = 1'b0;
    bus_resp_rdata = 64'd0;
    forever begin
      @(negedge clk);
      if (bus_en) begin
        bus_resp_valid = 1'b0;
        bus_resp_rdata = {$urandom, $urandom};
        if (resp_wait > 0) begin
          resp_wait--;
          if (resp_wait == 0) begin
            bus_resp_valid = 1'b1;
            bus_resp_rdata = resp_data;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          bus_resp_valid = 1'b1;
        end
        if (bus_req_valid && stall_n > 0) begin
          bus_req_ready = 1'b0;
          stall_n--;
        end else begin
          bus_req_ready = 1'($urandom_range(0, 1));
        end
        if (bus_req_valid) begin
          if (bus_q.size() == 0) begin
            fail_now("unexpected_bus_req");
          end else begin
            bb = bus_q[0];
            chk("bus_addr", bus_addr, bb.addr);
            chk("bus_wen", 64'(bus_wen), 64'(bb.wen));
            chk("bus_wstrb", 64'(bus_wstrb), 64'(bb.wstrb));
            chk("bus_wdata", bus_wdata, bb.wdata);
            if (bus_req_ready) begin
              void'(bus_q.pop_front());
              resp_data = bb.rdata;
              resp_wait = $urandom_range(1, 3);
            end
          end
        end
      end
    end
  end

  // Output monitor: compares each completed access against the queue.
  initial begin
    exp_t e;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_out_valid");
        end else begin
          e = exp_q.pop_front();
          chk("out_rdata", out_rdata, e.rdata);
          chk("out_err", 64'(out_err), 64'(e.err));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bus_t b;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_wen      = 1'b0;
    in_mask     = 4'd0;
    in_unsigned = 1'b0;
    in_addr     = 64'd0;
    in_wdata    = 64'd0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_bus_req_valid", 64'(bus_req_valid), 64'd0);
    chk("rst_out_rdata", out_rdata, 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_bus_wstrb", 64'(bus_wstrb), 64'd0);
    rst = 1'b0;

    // signed byte load from lane 3
    e = '{rdata: 64'hFFFF_FFFF_FFFF_FF80, err: 1'b0};
    b = '{addr: 64'h8000_0000, wen: 1'b0, wstrb: 8'h00,
          wdata: 64'd0, rdata: 64'h0000_0000_8000_0000};
    issue(1'b0, 4'b1000, 1'b0, 64'h8000_0003, 64'd0, e, 1'b1, b);
    drain();

    // half store into top lanes
    e = '{rdata: 64'd0, err: 1'b0};
    b = '{addr: 64'h8000_0000, wen: 1'b1, wstrb: 8'hC0,
          wdata: 64'hABCD_ABCD_ABCD_ABCD, rdata: 64'h5555_5555_5555_5555};
    issue(1'b1, 4'b0100, 1'b0, 64'h8000_0006, 64'h1234_ABCD, e, 1'b1, b);
    drain();

    // unsigned word load with a stalled bus
    e = '{rdata: 64'h0000_0000_8765_4321, err: 1'b0};
    b = '{addr: 64'h8000_0000, wen: 1'b0, wstrb: 8'h00,
          wdata: 64'd0, rdata: 64'h8765_4321_0000_0000};
    stall_n = 3;
    issue(1'b0, 4'b0010, 1'b1, 64'h8000_0004, 64'd0, e, 1'b1, b);
    drain();

    // misaligned word load
`ifdef YSYX_22040088_LSU_MISALIGN_CHK_EN
    e = '{rdata: 64'd0, err: 1'b1};
    b = '{addr: 64'h8000_0000, wen: 1'b0, wstrb: 8'h00,
          wdata: 64'd0, rdata: 64'd0};
    issue(1'b0, 4'b0010, 1'b0, 64'h8000_0002, 64'd0, e, 1'b0, b);
`else
    e = '{rdata: 64'h0000_0000_5566_7788, err: 1'b0};
    b = '{addr: 64'h8000_0000, wen: 1'b0, wstrb: 8'h00,
          wdata: 64'd0, rdata: 64'h1122_3344_5566_7788};
    issue(1'b0, 4'b0010, 1'b0, 64'h8000_0002, 64'd0, e, 1'b1, b);
`endif
    drain();

    // non-one-hot mask
    e = '{rdata: 64'd0, err: 1'b1};
    b = '{addr: 64'd0, wen: 1'b0, wstrb: 8'h00,
          wdata: 64'd0, rdata: 64'd0};
    issue(1'b0, 4'b0110, 1'b0, 64'h8000_0000, 64'd0, e, 1'b0, b);
    drain();

    // reset while waiting for the response, then a late response
    bus_en = 1'b0;
    bus_req_ready  = 1'b0;
    bus_resp_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_wen   = 1'b0;
    in_mask  = 4'b0010;
    in_addr  = 64'h8000_0010;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rstw_req_valid", 64'(bus_req_valid), 64'd1);
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
    chk("rstw_in_wait", 64'(bus_req_valid), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus_resp_valid = 1'b1;
    bus_resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    bus_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rstw_in_ready", 64'(in_ready), 64'd1);
      chk("rstw_out_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    resp_wait = 0;
    stall_n   = 0;
    bus_en    = 1'b1;

    for (int t = 0; t < 200; t++) rand_txn();
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
